// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package kbd_pkg;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    localparam int         PS2_DATA_BITS = 8;
    localparam logic [7:0] KEY_NONE      = 8'h00;

    // Saturating increment used by the frame-error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/ps2_edge_filter.sv
// PS/2 pin conditioning: 2-FF synchronisers on clock and data, a debounce
// filter on the clock (FILTER_LEN equal samples before the level changes)
// and a one-cycle strobe on each falling edge of the filtered clock.
module ps2_edge_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic CLK,
    input  logic reset,
    input  logic ps2_clock,
    input  logic ps2_data,
    output logic sample_strobe,
    output logic data_sync
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_filt;
    logic [CW-1:0] run_cnt;

    // Synchronise both pins; idle bus level is high.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clock};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    // Debounce: the filtered level follows only after FILTER_LEN disagreeing samples in a row.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            clk_filt      <= 1'b1;
            run_cnt       <= '0;
            sample_strobe <= 1'b0;
        end else begin
            sample_strobe <= 1'b0;
            if (clk_sync[1] == clk_filt) begin
                run_cnt <= '0;
            end else if (run_cnt == LAST) begin
                clk_filt      <= clk_sync[1];
                run_cnt       <= '0;
                sample_strobe <= clk_filt;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

    assign data_sync = dat_sync[1];

endmodule

// File: rtl/keyboard_rx_fifo.sv
// PS/2 keyboard receiver with scan-code FIFO and frame-error counting.
// Optional feature macro: KBD_PARITY_CHECK_EN (odd-parity check on frames).
//
// state     | meaning
// RX_IDLE   | waiting for a start bit (data low on strobe)
// RX_DATA   | shifting in 8 data bits, LSB first
// RX_PARITY | sampling the parity bit
// RX_STOP   | checking stop bit (and parity), pushing good frames
module keyboard_rx_fifo
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                        CLK,
    input  logic                        reset,
    input  logic                        keyboard_clock,
    input  logic                        keyboard_data,
    input  logic                        pop,
    output logic [7:0]                  pressed_key,
    output logic                        key_valid,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    output logic [7:0]                  frame_error_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(PS2_DATA_BITS);

    logic          strobe;
    logic          rx_data;
    rx_state_t     state;
    logic [BW-1:0] bit_cnt;
    logic [7:0]    shift;
    logic [TW-1:0] to_rem;
    logic          timeout;
    logic          frame_ok;
    logic          push_req;
    logic [7:0]    push_data;
`ifdef KBD_PARITY_CHECK_EN
    logic          par_bit;
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;
    logic [CW-1:0] count_next;
    logic [CW-1:0] remaining;
    logic [7:0]    head_next;
    logic          pop_ok;
    logic          push_ok;
    logic          full;

    ps2_edge_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .CLK           (CLK),
        .reset         (reset),
        .ps2_clock     (keyboard_clock),
        .ps2_data      (keyboard_data),
        .sample_strobe (strobe),
        .data_sync     (rx_data)
    );

    assign timeout = (state != RX_IDLE) && !strobe && (to_rem == '0);
`ifdef KBD_PARITY_CHECK_EN
    assign frame_ok = rx_data && (^{shift, par_bit});
`else
    assign frame_ok = rx_data;
`endif

    // Receiver FSM, inactivity timer (down-counter reloaded on every strobe) and error count.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state             <= RX_IDLE;
            bit_cnt           <= '0;
            shift             <= '0;
            to_rem            <= '0;
            push_req          <= 1'b0;
            push_data         <= KEY_NONE;
            frame_error_count <= 8'h00;
`ifdef KBD_PARITY_CHECK_EN
            par_bit           <= 1'b0;
`endif
        end else begin
            push_req <= 1'b0;
            if (strobe)
                to_rem <= TW'(TIMEOUT_CYCLES);
            else if (state != RX_IDLE && to_rem != '0)
                to_rem <= to_rem - 1'b1;

            if (timeout) begin
                state             <= RX_IDLE;
                frame_error_count <= sat_inc8(frame_error_count);
            end else if (strobe) begin
                case (state)
                    RX_IDLE: begin
                        if (!rx_data) begin
                            state   <= RX_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    RX_DATA: begin
                        shift   <= {rx_data, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BW'(PS2_DATA_BITS - 1))
                            state <= RX_PARITY;
                    end
                    RX_PARITY: begin
`ifdef KBD_PARITY_CHECK_EN
                        par_bit <= rx_data;
`endif
                        state <= RX_STOP;
                    end
                    RX_STOP: begin
                        state <= RX_IDLE;
                        if (frame_ok) begin
                            push_req  <= 1'b1;
                            push_data <= shift;
                        end else begin
                            frame_error_count <= sat_inc8(frame_error_count);
                        end
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

    // FIFO next-state: a pop on an empty FIFO is ignored; a full FIFO accepts a push only alongside a pop.
    always_comb begin
        full       = (fifo_count == CW'(FIFO_DEPTH));
        pop_ok     = pop && (fifo_count != '0);
        push_ok    = push_req && (!full || pop_ok);
        count_next = fifo_count + CW'(push_ok) - CW'(pop_ok);
        rd_next    = rd_ptr + AW'(pop_ok);
        remaining  = fifo_count - CW'(pop_ok);
        head_next  = KEY_NONE;
        if (remaining != '0)
            head_next = mem[rd_next];
        else if (push_ok)
            head_next = push_data;
    end

    // Registered FIFO state and outputs; the head is precomputed so the output is first-word-fall-through.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            key_valid   <= 1'b0;
            pressed_key <= KEY_NONE;
            overflow    <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr + AW'(push_ok);
            rd_ptr      <= rd_next;
            fifo_count  <= count_next;
            key_valid   <= (count_next != '0);
            pressed_key <= head_next;
            if (push_req && full && !pop_ok)
                overflow <= 1'b1;
            else if (pop_ok)
                overflow <= 1'b0;
        end
    end

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge CLK) begin
        if (push_ok)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: tb/tb_keyboard_rx_fifo.sv
// Directed bench for keyboard_rx_fifo (small timeout to keep runs short).
`timescale 1ns/1ps
module tb_keyboard_rx_fifo;
    localparam int FIFO_DEPTH = 8;
    localparam int FILTER_LEN = 4;
    localparam int TIMEOUT    = 300;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic       keyboard_clock = 1'b1;
    logic       keyboard_data = 1'b1;
    logic       pop = 1'b0;
    logic [7:0] pressed_key;
    logic       key_valid;
    logic [3:0] fifo_count;
    logic       overflow;
    logic [7:0] frame_error_count;

    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] exp_err = 8'h00;

    keyboard_rx_fifo #(
        .FIFO_DEPTH     (FIFO_DEPTH),
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .CLK               (CLK),
        .reset             (reset),
        .keyboard_clock    (keyboard_clock),
        .keyboard_data     (keyboard_data),
        .pop               (pop),
        .pressed_key       (pressed_key),
        .key_valid         (key_valid),
        .fifo_count        (fifo_count),
        .overflow          (overflow),
        .frame_error_count (frame_error_count)
    );

    always #5 CLK = ~CLK;

    // One PS/2 bit: data set up, clock low 8 cycles, high 8 cycles.
    // With pop_at_push the pop is placed on the edge where the stop-bit push lands
    // (strobe 6 edges after the fall, push request 7, FIFO write 8).
    task automatic drive_bit(input logic b, input logic pop_at_push);
        @(posedge CLK); #1 keyboard_data = b;
        repeat (4) @(posedge CLK);
        #1 keyboard_clock = 1'b0;
        if (pop_at_push) begin
            repeat (7) @(posedge CLK);
            #1 pop = 1'b1;
            @(posedge CLK);
            #1 pop = 1'b0;
        end else begin
            repeat (8) @(posedge CLK);
        end
        #1 keyboard_clock = 1'b1;
        repeat (8) @(posedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic pop_at_push);
        logic par;
        par = (~(^code)) ^ bad_par;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(code[i], 1'b0);
        drive_bit(par, 1'b0);
        drive_bit(1'b1, pop_at_push);
        #1;
    endtask

    task automatic do_pop();
        @(posedge CLK); #1 pop = 1'b1;
        @(posedge CLK); #1 pop = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge CLK);
        #1 reset = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        n_total++; if (key_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", key_valid); else n_pass++;
        n_total++; if (pressed_key !== 8'h00) $display("FAIL reset_key got %h want 00", pressed_key); else n_pass++;
        n_total++; if (fifo_count !== 4'd0) $display("FAIL reset_count got %0d want 0", fifo_count); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %0b want 0", overflow); else n_pass++;
        n_total++; if (frame_error_count !== 8'h00) $display("FAIL reset_err got %h want 00", frame_error_count); else n_pass++;
    endtask

    task automatic test_single();
        send_frame(8'h1C, 1'b0, 1'b0);
        n_total++; if (key_valid !== 1'b1) $display("FAIL single_valid got %0b want 1", key_valid); else n_pass++;
        n_total++; if (pressed_key !== 8'h1C) $display("FAIL single_key got %h want 1c", pressed_key); else n_pass++;
        n_total++; if (fifo_count !== 4'd1) $display("FAIL single_count got %0d want 1", fifo_count); else n_pass++;
        do_pop();
        n_total++; if (key_valid !== 1'b0) $display("FAIL single_pop_valid got %0b want 0", key_valid); else n_pass++;
        n_total++; if (pressed_key !== 8'h00) $display("FAIL single_pop_key got %h want 00", pressed_key); else n_pass++;
        n_total++; if (fifo_count !== 4'd0) $display("FAIL single_pop_count got %0d want 0", fifo_count); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [7:0] exp_key;
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
        n_total++; if (fifo_count !== 4'd8) $display("FAIL ovf_count got %0d want 8", fifo_count); else n_pass++;
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %0b want 1", overflow); else n_pass++;
        for (int i = 1; i <= 8; i++) begin
            exp_key = 8'(i);
            n_total++; if (pressed_key !== exp_key) $display("FAIL ovf_drain_key%0d got %h want %h", i, pressed_key, exp_key); else n_pass++;
            do_pop();
            if (i == 1) begin
                n_total++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %0b want 0", overflow); else n_pass++;
            end
        end
        n_total++; if (key_valid !== 1'b0) $display("FAIL ovf_empty_valid got %0b want 0", key_valid); else n_pass++;
        do_pop();
        n_total++; if (fifo_count !== 4'd0) $display("FAIL pop_empty_count got %0d want 0", fifo_count); else n_pass++;
        n_total++; if (pressed_key !== 8'h00) $display("FAIL pop_empty_key got %h want 00", pressed_key); else n_pass++;
    endtask

    task automatic test_parity();
        send_frame(8'h5A, 1'b1, 1'b0);
`ifdef KBD_PARITY_CHECK_EN
        exp_err = exp_err + 8'd1;
        n_total++; if (fifo_count !== 4'd0) $display("FAIL parity_count got %0d want 0", fifo_count); else n_pass++;
        n_total++; if (frame_error_count !== exp_err) $display("FAIL parity_err got %h want %h", frame_error_count, exp_err); else n_pass++;
`else
        n_total++; if (fifo_count !== 4'd1) $display("FAIL parity_count got %0d want 1", fifo_count); else n_pass++;
        n_total++; if (pressed_key !== 8'h5A) $display("FAIL parity_key got %h want 5a", pressed_key); else n_pass++;
        n_total++; if (frame_error_count !== exp_err) $display("FAIL parity_err got %h want %h", frame_error_count, exp_err); else n_pass++;
        do_pop();
`endif
    endtask

    task automatic test_timeout();
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
        repeat (TIMEOUT + 50) @(posedge CLK);
        #1;
        exp_err = exp_err + 8'd1;
        n_total++; if (frame_error_count !== exp_err) $display("FAIL timeout_err got %h want %h", frame_error_count, exp_err); else n_pass++;
        n_total++; if (fifo_count !== 4'd0) $display("FAIL timeout_count got %0d want 0", fifo_count); else n_pass++;
        send_frame(8'h29, 1'b0, 1'b0);
        n_total++; if (pressed_key !== 8'h29) $display("FAIL timeout_next_key got %h want 29", pressed_key); else n_pass++;
        n_total++; if (fifo_count !== 4'd1) $display("FAIL timeout_next_count got %0d want 1", fifo_count); else n_pass++;
        do_pop();
    endtask

    // A spurious strobe here would start a frame (data low) that later times out.
    task automatic test_glitch();
        @(posedge CLK); #1 keyboard_data = 1'b0; keyboard_clock = 1'b0;
        repeat (FILTER_LEN - 1) @(posedge CLK);
        #1 keyboard_clock = 1'b1;
        repeat (TIMEOUT + 50) @(posedge CLK);
        #1 keyboard_data = 1'b1;
        n_total++; if (frame_error_count !== exp_err) $display("FAIL glitch_err got %h want %h", frame_error_count, exp_err); else n_pass++;
        n_total++; if (fifo_count !== 4'd0) $display("FAIL glitch_count got %0d want 0", fifo_count); else n_pass++;
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_key;
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0);
        n_total++; if (fifo_count !== 4'd8) $display("FAIL fullpp_pre_count got %0d want 8", fifo_count); else n_pass++;
        send_frame(8'h18, 1'b0, 1'b1);
        n_total++; if (fifo_count !== 4'd8) $display("FAIL fullpp_count got %0d want 8", fifo_count); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL fullpp_ovf got %0b want 0", overflow); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            exp_key = 8'h11 + 8'(i);
            n_total++; if (pressed_key !== exp_key) $display("FAIL fullpp_drain%0d got %h want %h", i, pressed_key, exp_key); else n_pass++;
            do_pop();
        end
        n_total++; if (fifo_count !== 4'd0) $display("FAIL fullpp_end_count got %0d want 0", fifo_count); else n_pass++;
    endtask

    task automatic test_empty_push_pop();
        send_frame(8'h3B, 1'b0, 1'b1);
        n_total++; if (fifo_count !== 4'd1) $display("FAIL emptypp_count got %0d want 1", fifo_count); else n_pass++;
        n_total++; if (pressed_key !== 8'h3B) $display("FAIL emptypp_key got %h want 3b", pressed_key); else n_pass++;
        do_pop();
    endtask

    task automatic test_reset_midframe();
        send_frame(8'h41, 1'b0, 1'b0);
        send_frame(8'h42, 1'b0, 1'b0);
        send_frame(8'h43, 1'b0, 1'b0);
        n_total++; if (fifo_count !== 4'd3) $display("FAIL midrst_pre_count got %0d want 3", fifo_count); else n_pass++;
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        @(posedge CLK); #1 keyboard_clock = 1'b0;
        #2 reset = 1'b0;
        #1;
        n_total++; if (key_valid !== 1'b0) $display("FAIL midrst_valid got %0b want 0", key_valid); else n_pass++;
        n_total++; if (pressed_key !== 8'h00) $display("FAIL midrst_key got %h want 00", pressed_key); else n_pass++;
        n_total++; if (fifo_count !== 4'd0) $display("FAIL midrst_count got %0d want 0", fifo_count); else n_pass++;
        n_total++; if (frame_error_count !== 8'h00) $display("FAIL midrst_err got %h want 00", frame_error_count); else n_pass++;
        repeat (2) @(posedge CLK);
        #1 keyboard_clock = 1'b1; keyboard_data = 1'b1;
        repeat (2) @(posedge CLK);
        #1 reset = 1'b1;
        exp_err = 8'h00;
        repeat (4) @(posedge CLK);
        send_frame(8'h76, 1'b0, 1'b0);
        n_total++; if (pressed_key !== 8'h76) $display("FAIL midrst_next_key got %h want 76", pressed_key); else n_pass++;
        n_total++; if (fifo_count !== 4'd1) $display("FAIL midrst_next_count got %0d want 1", fifo_count); else n_pass++;
        n_total++; if (frame_error_count !== exp_err) $display("FAIL midrst_next_err got %h want %h", frame_error_count, exp_err); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_parity();
        test_timeout();
        test_glitch();
        test_full_push_pop();
        test_empty_push_pop();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/keyboard_rx_fifo.md
# keyboard_rx_fifo

PS/2 keyboard receiver with a parametrised scan-code FIFO, debounced clock input and frame-error accounting. It replaces the single-byte keyboard buffer on the CPU clock domain. It sits between the PS/2 pins and the memory-mapped keyboard port. Software can drain several buffered scan codes instead of losing keys between polls.

## Interface
- FIFO_DEPTH, 8, scan-code entries; power of two, ≥2
- FILTER_LEN, 4, consecutive equal CLK samples needed before the filtered PS/2 clock changes level
- TIMEOUT_CYCLES, 50000, CLK cycles without a PS/2 falling edge before an in-progress frame is aborted
- CLK  input  1  CPU clock; all logic is on this single clock
- reset  input  1  asynchronous, active-low reset
- keyboard_clock  input  1  raw PS/2 clock pin, asynchronous
- keyboard_data  input  1  raw PS/2 data pin, asynchronous
- pop  input  1  removes the FIFO head this cycle; ignored when the FIFO is empty
- pressed_key  output  8  FIFO head scan code, first-word-fall-through; 8'h00 when empty
- key_valid  output  1  FIFO non-empty
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of entries held
- overflow  output  1  sticky; set when a frame is dropped because the FIFO is full; cleared by an accepted pop
- frame_error_count  output  8  saturating count of discarded frames (bad stop bit, timeout, bad parity)

## Operation
- Both pins pass through a 2-FF synchroniser. The clock path then goes through the FILTER_LEN filter. A falling edge of the filtered clock produces a 1-cycle sample strobe.
- Receiver FSM states:
  - RX_IDLE: on strobe with data=0 (start bit), go to RX_DATA with the bit counter at 0. On strobe with data=1, stay in RX_IDLE.
  - RX_DATA: on each strobe, shift data in LSB first. After the 8th bit, go to RX_PARITY.
  - RX_PARITY: on strobe, capture the parity bit and go to RX_STOP.
  - RX_STOP: on strobe, the frame is good if data=1 and the parity check passes (see Configuration). A good frame is pushed. A bad frame increments frame_error_count. Either way, return to RX_IDLE.
- Timeout: the counter clears on every strobe and counts while the FSM is not in RX_IDLE. On reaching TIMEOUT_CYCLES, the FSM returns to RX_IDLE, the partial frame is discarded and frame_error_count increments.
- frame_error_count saturates at 8'hFF.
- FIFO uses a circular buffer with wrap-around pointers; count width is one bit wider than the address.
  - Push when full: byte dropped, overflow set, count unchanged.
  - Push and pop in the same cycle when full: both accepted, count unchanged, overflow not set.
  - Push and pop in the same cycle when empty: pop ignored, push accepted, count becomes 1.
  - Pop when empty: no effect, overflow unchanged.
- Reset, at any point including mid-frame: FSM goes to RX_IDLE, pointers, count and timeout are cleared, and all outputs are 0. Filter and synchroniser registers reset to 1 (bus idle).

## Timing
- Pin edge to sample strobe: 2 + FILTER_LEN CLK cycles.
- The push occurs in the cycle after the stop-bit strobe. key_valid, pressed_key and fifo_count reflect the push on the following edge.
- Pop is seen at the clock edge. The new head appears on pressed_key on the same edge and fifo_count decrements on the same edge.
- All outputs are registered; there are no combinational paths from pins or pop to outputs.

## Configuration
- KBD_PARITY_CHECK_EN defined: the stop-state check also requires odd parity over the 8 data bits plus the parity bit. Frames with bad parity are dropped and counted.
- KBD_PARITY_CHECK_EN undefined: the parity bit is sampled but ignored. Only the stop bit and the timeout cause errors.

## Structure
- Shared package kbd_pkg holds:
  - rx_state_t enum {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP}
  - PS2_DATA_BITS = 8
  - KEY_NONE = 8'h00
- One sub-module, ps2_edge_filter, contains the synchroniser, the FILTER_LEN debounce and falling-edge strobe generation. It outputs the strobe and the synchronised data. The FSM and FIFO live in the top.

## Test plan
- Frame 8'h1C with correct parity, pop held low -> key_valid=1, pressed_key=8'h1C, fifo_count=1. Then pop for 1 cycle -> key_valid=0, pressed_key=8'h00.
- Frames 8'h01..8'h09 with FIFO_DEPTH=8 and no pops -> fifo_count=8, overflow=1. Eight pops return 8'h01..8'h08; 8'h09 is absent. overflow clears on the first pop.
- Frame 8'h5A with inverted parity -> with the macro: no push, frame_error_count=1. Without the macro: pushed, error count 0.
- Start bit plus 4 data bits, then the clock held high for TIMEOUT_CYCLES -> FSM in RX_IDLE, no push, frame_error_count=1. A following 8'h29 frame is received correctly.
- PS/2 clock low glitch of FILTER_LEN-1 cycles while idle -> no strobe, no state change. FIFO full plus a push coinciding with a pop -> count stays 8, overflow=0, new byte at the tail.
- reset low mid-frame with 3 entries held -> outputs 0 immediately, asynchronously. After release, frame 8'h76 gives pressed_key=8'h76 and fifo_count=1.
